// File: rtl/alu_multiword_sequencer_pkg.sv
// Shared opcode encoding and sequencer state type for the narrow ALU,
// the multiword sequencer and anything that issues commands to them.
package alu_multiword_sequencer_pkg;

  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_ADD_CARRY = 4'd2;
  localparam logic [3:0] OP_SUB       = 4'd3;
  localparam logic [3:0] OP_INC       = 4'd4;
  localparam logic [3:0] OP_DEC       = 4'd5;
  localparam logic [3:0] OP_AND       = 4'd6;
  localparam logic [3:0] OP_NOT       = 4'd7;
  localparam logic [3:0] OP_ROL       = 4'd8;
  localparam logic [3:0] OP_ROR       = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Rotates have no meaningful chunked form, so only 1..7 run at wide width.
  function automatic logic is_wide_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

  // Carry fed into the least significant chunk for each wide opcode.
  function automatic logic initial_carry(input logic [3:0] op, input logic cin);
    case (op)
      OP_ADD_CARRY:   return cin;
      OP_SUB, OP_INC: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_multiword_sequencer_if.sv
// Command/response handshake bundle between the issue logic (master)
// and the multiword sequencer (slave).
interface alu_multiword_sequencer_if #(
  parameter int BUS_WIDTH = 8,
  parameter int WORDS     = 4
);
  localparam int W = BUS_WIDTH * WORDS;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_opcode;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_carry_in;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_carry_out;
  logic         rsp_borrow;
  logic         rsp_zero;
  logic         rsp_parity;
  logic         rsp_invalid;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_carry_in, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_y, rsp_carry_out, rsp_borrow,
           rsp_zero, rsp_parity, rsp_invalid
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_carry_in, rsp_ready,
    output cmd_ready, rsp_valid, rsp_y, rsp_carry_out, rsp_borrow,
           rsp_zero, rsp_parity, rsp_invalid
  );

endinterface

// File: rtl/alu_multiword_sequencer_alu.sv
// Single-width combinational ALU; the multiword sequencer steps it one
// chunk per clock.
module ALU
  import alu_multiword_sequencer_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic [3:0]           opcode,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op
);

  localparam logic [BUS_WIDTH:0] ONE = {{BUS_WIDTH{1'b0}}, 1'b1};

  logic [BUS_WIDTH:0] ext;

  always_comb begin
    ext        = '0;
    y          = '0;
    carry_out  = 1'b0;
    borrow     = 1'b0;
    invalid_op = 1'b0;
    case (opcode)
      OP_ADD: begin
        ext       = {1'b0, a} + {1'b0, b};
        y         = ext[BUS_WIDTH-1:0];
        carry_out = ext[BUS_WIDTH];
      end
      OP_ADD_CARRY: begin
        ext       = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, carry_in};
        y         = ext[BUS_WIDTH-1:0];
        carry_out = ext[BUS_WIDTH];
      end
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        y      = ext[BUS_WIDTH-1:0];
        borrow = ext[BUS_WIDTH];
      end
      OP_INC: begin
        ext       = {1'b0, a} + ONE;
        y         = ext[BUS_WIDTH-1:0];
        carry_out = ext[BUS_WIDTH];
      end
      OP_DEC: begin
        ext    = {1'b0, a} - ONE;
        y      = ext[BUS_WIDTH-1:0];
        borrow = ext[BUS_WIDTH];
      end
      OP_AND: y = a & b;
      OP_NOT: y = ~a;
      // Rotates report the bit that wrapped around as carry_out.
      OP_ROL: begin
        y         = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
        carry_out = a[BUS_WIDTH-1];
      end
      OP_ROR: begin
        y         = {a[0], a[BUS_WIDTH-1:1]};
        carry_out = a[0];
      end
      default: invalid_op = 1'b1;
    endcase
    zero   = (y == '0);
    parity = ^y;
  end

endmodule

// File: rtl/alu_multiword_sequencer.sv
// Runs the narrow ALU across WORDS chunks, LSB first, chaining carry in a
// register and folding per-chunk zero/parity into wide response flags.
module alu_multiword_sequencer
  import alu_multiword_sequencer_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int WORDS     = 4
) (
  input logic                    clk,
  input logic                    reset,
  alu_multiword_sequencer_if.slave bus
);

  localparam int W     = BUS_WIDTH * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t               state, next_state;
  logic [IDX_W-1:0]     idx;
  logic [3:0]           op_q;
  logic [W-1:0]         a_q, b_q;
  logic                 carry_q, zero_acc, parity_acc;
  logic                 accept, last_chunk;

  logic [3:0]           alu_op;
  logic [BUS_WIDTH-1:0] alu_a, alu_b, alu_y;
  logic                 alu_cout, alu_zero, alu_parity;
  logic                 alu_borrow_unused, alu_invalid_unused;

  assign accept     = bus.cmd_valid & bus.cmd_ready;
  assign last_chunk = (state == EXEC) && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = !reset;
        if (bus.cmd_valid && !reset)
          next_state = is_wide_op(bus.cmd_opcode) ? EXEC : DONE;
      end
      EXEC: if (last_chunk) next_state = DONE;
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Arithmetic ops all map onto add-with-carry; only the B chunk and the
  // initial carry (loaded at accept) distinguish them.
  always_comb begin
    alu_op = OP_ADD_CARRY;
    alu_a  = a_q[idx*BUS_WIDTH +: BUS_WIDTH];
    alu_b  = b_q[idx*BUS_WIDTH +: BUS_WIDTH];
    case (op_q)
      OP_SUB: alu_b  = ~b_q[idx*BUS_WIDTH +: BUS_WIDTH];
      OP_INC: alu_b  = '0;
      OP_DEC: alu_b  = '1;
      OP_AND: alu_op = OP_AND;
      OP_NOT: alu_op = OP_NOT;
      default: ;
    endcase
  end

  ALU #(.BUS_WIDTH(BUS_WIDTH)) u_alu (
    .opcode    (alu_op),
    .a         (alu_a),
    .b         (alu_b),
    .carry_in  (carry_q),
    .y         (alu_y),
    .carry_out (alu_cout),
    .borrow    (alu_borrow_unused),
    .zero      (alu_zero),
    .parity    (alu_parity),
    .invalid_op(alu_invalid_unused)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx               <= '0;
      op_q              <= '0;
      a_q               <= '0;
      b_q               <= '0;
      carry_q           <= 1'b0;
      zero_acc          <= 1'b0;
      parity_acc        <= 1'b0;
      bus.rsp_y         <= '0;
      bus.rsp_carry_out <= 1'b0;
      bus.rsp_borrow    <= 1'b0;
      bus.rsp_zero      <= 1'b0;
      bus.rsp_parity    <= 1'b0;
      bus.rsp_invalid   <= 1'b0;
    end else if (accept) begin
      idx        <= '0;
      op_q       <= bus.cmd_opcode;
      a_q        <= bus.cmd_a;
      b_q        <= bus.cmd_b;
      carry_q    <= initial_carry(bus.cmd_opcode, bus.cmd_carry_in);
      zero_acc   <= 1'b1;
      parity_acc <= 1'b0;
      bus.rsp_invalid <= !is_wide_op(bus.cmd_opcode);
      if (!is_wide_op(bus.cmd_opcode)) begin
        bus.rsp_y         <= '0;
        bus.rsp_carry_out <= 1'b0;
        bus.rsp_borrow    <= 1'b0;
        bus.rsp_zero      <= 1'b1;
        bus.rsp_parity    <= 1'b0;
      end
    end else if (state == EXEC) begin
      bus.rsp_y[idx*BUS_WIDTH +: BUS_WIDTH] <= alu_y;
      carry_q    <= alu_cout;
      zero_acc   <= zero_acc & alu_zero;
      parity_acc <= parity_acc ^ alu_parity;
      // Subtract/decrement run as add of the complement, so borrow is ~carry.
      if (last_chunk) begin
        idx               <= '0;
        bus.rsp_zero      <= zero_acc & alu_zero;
        bus.rsp_parity    <= parity_acc ^ alu_parity;
        bus.rsp_carry_out <= alu_cout & ((op_q == OP_ADD) || (op_q == OP_ADD_CARRY) || (op_q == OP_INC));
        bus.rsp_borrow    <= ~alu_cout & ((op_q == OP_SUB) || (op_q == OP_DEC));
      end else begin
        idx <= idx + IDX_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// Scoreboard bench for the multiword sequencer: a wide-arithmetic model
// queues expected responses at issue, popped when rsp_valid appears.
module tb_alu_multiword_sequencer;
  import alu_multiword_sequencer_pkg::*;

  localparam int BW    = 8;
  localparam int WORDS = 4;
  localparam int W     = BW * WORDS;

  typedef struct packed {
    logic [W-1:0] y;
    logic         carry_out;
    logic         borrow;
    logic         zero;
    logic         parity;
    logic         invalid;
  } rsp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } cmd_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  rsp_t exp_q[$];

  alu_multiword_sequencer_if #(.BUS_WIDTH(BW), .WORDS(WORDS)) bus();

  alu_multiword_sequencer #(.BUS_WIDTH(BW), .WORDS(WORDS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic rsp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    rsp_t       r;
    logic [W:0] ext;
    r   = '0;
    ext = '0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        r.y = ext[W-1:0];
        r.carry_out = ext[W];
      end
      OP_ADD_CARRY: begin
        ext = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r.y = ext[W-1:0];
        r.carry_out = ext[W];
      end
      OP_SUB: begin
        r.y = a - b;
        r.borrow = (a < b);
      end
      OP_INC: begin
        r.y = a + 32'd1;
        r.carry_out = (a == 32'hFFFF_FFFF);
      end
      OP_DEC: begin
        r.y = a - 32'd1;
        r.borrow = (a == 32'd0);
      end
      OP_AND:  r.y = a & b;
      OP_NOT:  r.y = ~a;
      default: r.invalid = 1'b1;
    endcase
    r.zero   = (r.y == '0);
    r.parity = ^r.y;
    return r;
  endfunction

  function automatic rsp_t observe();
    return {bus.rsp_y, bus.rsp_carry_out, bus.rsp_borrow,
            bus.rsp_zero, bus.rsp_parity, bus.rsp_invalid};
  endfunction

  // Presents a command and returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, output bit ok);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid    = 1'b1;
    bus.cmd_opcode   = op;
    bus.cmd_a        = a;
    bus.cmd_b        = b;
    bus.cmd_carry_in = cin;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = bus.cmd_ready;
    if (ok) begin
      exp_q.push_back(model(op, a, b, cin));
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.rsp_valid && lat < 40);
  endtask

  task automatic consume();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rsp_t obs;
    repeat (2) @(negedge clk);
    obs = observe();
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_cmd_ready got=%b want=0", bus.cmd_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid);
    end
    checks++;
    if (obs !== rsp_t'(0)) begin
      failures++;
      $display("[TB] FAIL reset_rsp_fields got=%h want=0", obs);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_cmd_ready got=%b want=1", bus.cmd_ready);
    end
  endtask

  task automatic test_arith();
    cmd_t tbl[6];
    bit   ok;
    int   lat;
    rsp_t exp, obs;
    tbl[0] = '{OP_ADD,       32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    tbl[1] = '{OP_ADD_CARRY, 32'h1234_5678, 32'h1111_1111, 1'b1};
    tbl[2] = '{OP_SUB,       32'h0000_0000, 32'h0000_0001, 1'b0};
    tbl[3] = '{OP_SUB,       32'h0000_0005, 32'h0000_0003, 1'b0};
    tbl[4] = '{OP_INC,       32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[5] = '{OP_DEC,       32'h0000_0000, 32'h0000_0000, 1'b0};
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL arith%0d_accept got=no_accept want=accept", i);
        continue;
      end
      wait_rsp(lat);
      checks++;
      if (lat !== WORDS) begin
        failures++;
        $display("[TB] FAIL arith%0d_latency got=%0d want=%0d", i, lat, WORDS);
      end
      exp = exp_q.pop_front();
      obs = observe();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL arith%0d_result got=%h want=%h", i, obs, exp);
      end
      consume();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL arith%0d_rsp_drop got=%b want=0", i, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_invalid_hold();
    bit   ok;
    int   lat;
    rsp_t exp, obs;
    issue(4'd9, 32'h0000_00AB, 32'h0, 1'b0, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL invalid_accept got=no_accept want=accept");
      return;
    end
    wait_rsp(lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("[TB] FAIL invalid_latency got=%0d want=1", lat);
    end
    exp = exp_q.pop_front();
    for (int c = 0; c < 3; c++) begin
      obs = observe();
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready, obs} !== {1'b1, 1'b0, exp}) begin
        failures++;
        $display("[TB] FAIL invalid_hold%0d got=%b%b_%h want=10_%h",
                 c, bus.rsp_valid, bus.cmd_ready, obs, exp);
      end
      @(posedge clk);
      #1;
    end
    consume();
    checks++;
    if (bus.rsp_valid !== 1'b0 || observe() !== exp) begin
      failures++;
      $display("[TB] FAIL invalid_after_hs got=%b_%h want=0_%h", bus.rsp_valid, observe(), exp);
    end
  endtask

  task automatic test_reset_abort();
    bit   ok;
    int   lat;
    rsp_t exp, obs;
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL abort_accept got=no_accept want=accept");
    end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    obs = observe();
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, obs} !== {2'b00, rsp_t'(0)}) begin
      failures++;
      $display("[TB] FAIL abort_async_clear got=%b%b_%h want=00_0", bus.rsp_valid, bus.cmd_ready, obs);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(OP_ADD, 32'h1, 32'h1, 1'b1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL post_abort_accept got=no_accept want=accept");
      return;
    end
    wait_rsp(lat);
    exp = exp_q.pop_front();
    obs = observe();
    checks++;
    if (lat !== WORDS || obs !== exp) begin
      failures++;
      $display("[TB] FAIL post_abort_add lat=%0d got=%h want lat=%0d %h", lat, obs, WORDS, exp);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    bit         ok;
    int         lat, want_lat;
    logic [3:0] op;
    rsp_t       exp, obs;
    for (int i = 0; i < 10; i++) begin
      op = (i == 4) ? 4'd0 : (i == 7) ? 4'd12 : 4'($urandom_range(1, 7));
      want_lat = (op >= 4'd1 && op <= 4'd7) ? WORDS : 1;
      issue(op, $urandom, $urandom, 1'($urandom_range(0, 1)), ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL b2b%0d_accept op=%0d got=no_accept want=accept", i, op);
        continue;
      end
      wait_rsp(lat);
      checks++;
      if (lat !== want_lat) begin
        failures++;
        $display("[TB] FAIL b2b%0d_latency op=%0d got=%0d want=%0d", i, op, lat, want_lat);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      obs = observe();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL b2b%0d_result op=%0d got=%h want=%h", i, op, obs, exp);
      end
      consume();
    end
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_opcode   = '0;
    bus.cmd_a        = '0;
    bus.cmd_b        = '0;
    bus.cmd_carry_in = 1'b0;
    bus.rsp_ready    = 1'b0;
    test_reset();
    test_arith();
    test_invalid_hold();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
